// File: rtl/revolver_sprite.sv
// Revolver overlay sprite: slides toward the active player once per frame, kicks up on fire,
// and drives the pixel-relative geometry the colour mapper uses to address the sprite ROM.
module revolver_sprite #(
   parameter int unsigned X_CENTER      = 320,
   parameter int unsigned X_RED         = 160,
   parameter int unsigned X_BLUE        = 480,
   parameter int unsigned Y_REST        = 64,
   parameter int unsigned HALF          = 64,
   parameter int unsigned STEP          = 4,
   parameter int unsigned RECOIL_DY     = 16,
   parameter int unsigned RECOIL_FRAMES = 6
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic [3:0] cur_game_state,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   output logic       is_ball,
   output logic [9:0] Ball_x_dis,
   output logic [9:0] Ball_y_dis,
   output logic [9:0] Ball_X_Pos,
   output logic [9:0] Ball_Y_Pos,
   output logic       settled
);

   typedef enum logic [1:0] {StHidden, StTrack, StRecoil} state_e;

   localparam logic [9:0]        XC   = 10'(X_CENTER);
   localparam logic [9:0]        XR   = 10'(X_RED);
   localparam logic [9:0]        XB   = 10'(X_BLUE);
   localparam logic [9:0]        YR   = 10'(Y_REST);
   localparam logic [9:0]        YK   = 10'(Y_REST - RECOIL_DY);
   localparam logic [9:0]        STP  = 10'(STEP);
   localparam logic [3:0]        CNT  = 4'(RECOIL_FRAMES);
   localparam logic signed [10:0] H_LO = 11'(-int'(HALF));
   localparam logic signed [10:0] H_HI = 11'(int'(HALF) - 1);

   state_e     state_q, state_d;
   logic [2:0] fs_q;
   logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d, tgt_q, tgt_d, step_x;
   logic [3:0] cnt_q, cnt_d;
   logic       armed_q, armed_d, settled_q, settled_d;
   logic       tick, hidden, fire;

   // fs_q[1:0] synchronise vsync; fs_q[2] holds the previous sample for edge detect
   assign tick   = fs_q[1] & ~fs_q[2];
   assign hidden = (cur_game_state == 4'hF) || (cur_game_state == 4'h0);
   assign fire   = (cur_game_state == 4'h3);

   always_comb begin
      tgt_d = tgt_q;
      case (cur_game_state)
         4'h1:             tgt_d = XR;
         4'h2:             tgt_d = XB;
         4'h0, 4'h3, 4'hF: tgt_d = tgt_q;
         default:          tgt_d = XC;
      endcase
   end

   always_comb begin
      step_x = pos_x_q;
      if (tgt_d > pos_x_q) begin
         step_x = (tgt_d - pos_x_q <= STP) ? tgt_d : pos_x_q + STP;
      end else if (tgt_d < pos_x_q) begin
         step_x = (pos_x_q - tgt_d <= STP) ? tgt_d : pos_x_q - STP;
      end
   end

   always_comb begin
      state_d = state_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      cnt_d   = cnt_q;
      armed_d = fire ? armed_q : 1'b1;
      case (state_q)
         StHidden: begin
            pos_x_d = XC;
            pos_y_d = YR;
            cnt_d   = '0;
            if (!hidden) state_d = StTrack;
         end
         StTrack: begin
            if (hidden) begin
               state_d = StHidden;
               pos_x_d = XC;
               pos_y_d = YR;
            end else if (fire && armed_q) begin
               state_d = StRecoil;
               pos_y_d = YK;
               cnt_d   = CNT;
               armed_d = 1'b0;
            end else if (tick) begin
               pos_x_d = step_x;
            end
         end
         StRecoil: begin
            if (hidden) begin
               state_d = StHidden;
               pos_x_d = XC;
               pos_y_d = YR;
               cnt_d   = '0;
            end else if (tick) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q <= 4'd1) begin
                  pos_y_d = YR;
                  state_d = StTrack;
               end
            end
         end
         default: state_d = StHidden;
      endcase
      settled_d = (state_d == StHidden) || ((state_d == StTrack) && (pos_x_d == tgt_d));
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= StHidden;
         fs_q      <= '0;
         pos_x_q   <= XC;
         pos_y_q   <= YR;
         tgt_q     <= XC;
         cnt_q     <= '0;
         armed_q   <= 1'b1;
         settled_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         fs_q      <= {fs_q[1:0], frame_clk};
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         tgt_q     <= tgt_d;
         cnt_q     <= cnt_d;
         armed_q   <= armed_d;
         settled_q <= settled_d;
      end
   end

   logic signed [10:0] dx, dy;
   assign dx = $signed({1'b0, DrawX} - {1'b0, pos_x_q});
   assign dy = $signed({1'b0, DrawY} - {1'b0, pos_y_q});

   assign is_ball    = (state_q != StHidden) && (dx >= H_LO) && (dx <= H_HI)
                       && (dy >= H_LO) && (dy <= H_HI);
   assign Ball_x_dis = dx[9:0];
   assign Ball_y_dis = dy[9:0];
   assign Ball_X_Pos = pos_x_q;
   assign Ball_Y_Pos = pos_y_q;
   assign settled    = settled_q;

endmodule

// File: tb/tb_revolver_sprite.sv
// Directed bench for revolver_sprite: table of frame-stepped vectors, then fire/abort/reset
// sequences with hand-computed positions and geometry.
module tb_revolver_sprite;

   logic       Clk, Reset_n, frame_clk;
   logic [3:0] cur_game_state;
   logic [9:0] DrawX, DrawY;
   logic       is_ball, settled;
   logic [9:0] Ball_x_dis, Ball_y_dis, Ball_X_Pos, Ball_Y_Pos;

   int total = 0;
   int bad   = 0;

   revolver_sprite dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .frame_clk      (frame_clk),
      .cur_game_state (cur_game_state),
      .DrawX          (DrawX),
      .DrawY          (DrawY),
      .is_ball        (is_ball),
      .Ball_x_dis     (Ball_x_dis),
      .Ball_y_dis     (Ball_y_dis),
      .Ball_X_Pos     (Ball_X_Pos),
      .Ball_Y_Pos     (Ball_Y_Pos),
      .settled        (settled)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [3:0] st;
      logic [9:0] drx, dry;
      int         ticks;
      logic [9:0] ex, ey;
      logic       es, eb;
      logic [9:0] exd, eyd;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic tick_n(input int n);
      for (int k = 0; k < n; k++) begin
         frame_clk = 1'b1;
         cyc(4);
         frame_clk = 1'b0;
         cyc(4);
      end
   endtask

   task automatic chk_pos(input string nm, input logic [9:0] ex, input logic [9:0] ey,
                          input logic es);
      chk({nm, "_x"}, 16'(Ball_X_Pos), 16'(ex));
      chk({nm, "_y"}, 16'(Ball_Y_Pos), 16'(ey));
      chk({nm, "_settled"}, 16'(settled), 16'(es));
   endtask

   initial begin
      //           st     drawX   drawY  ticks  x       y      set   ball  xdis     ydis
      vt[0] = '{4'h0, 10'd320, 10'd64,  0, 10'd320, 10'd64, 1'b1, 1'b0, 10'h000, 10'h000};
      vt[1] = '{4'h1, 10'd320, 10'd64,  0, 10'd320, 10'd64, 1'b0, 1'b1, 10'h000, 10'h000};
      vt[2] = '{4'h1, 10'd300, 10'd70,  1, 10'd316, 10'd64, 1'b0, 1'b1, 10'h3F0, 10'h006};
      vt[3] = '{4'h1, 10'd100, 10'd10, 38, 10'd164, 10'd64, 1'b0, 1'b1, 10'h3C0, 10'h3CA};
      vt[4] = '{4'h1, 10'd100, 10'd10,  1, 10'd160, 10'd64, 1'b1, 1'b1, 10'h3C4, 10'h3CA};
      vt[5] = '{4'h1, 10'd224, 10'd128, 2, 10'd160, 10'd64, 1'b1, 1'b0, 10'h040, 10'h040};
      vt[6] = '{4'h2, 10'd223, 10'd127, 0, 10'd160, 10'd64, 1'b0, 1'b1, 10'h03F, 10'h03F};
      vt[7] = '{4'h2, 10'd476, 10'd0,  79, 10'd476, 10'd64, 1'b0, 1'b1, 10'h000, 10'h3C0};
      vt[8] = '{4'h2, 10'd480, 10'd64,  1, 10'd480, 10'd64, 1'b1, 1'b1, 10'h000, 10'h000};
      vt[9] = '{4'h2, 10'd543, 10'd64,  2, 10'd480, 10'd64, 1'b1, 1'b1, 10'h03F, 10'h000};

      Reset_n = 1'b0;
      frame_clk = 1'b0;
      cur_game_state = 4'h0;
      DrawX = 10'd320;
      DrawY = 10'd64;
      cyc(3);
      @(negedge Clk);
      chk_pos("in_reset", 10'd320, 10'd64, 1'b1);
      chk("in_reset_ball", 16'(is_ball), 16'd0);
      cyc(1);
      Reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         cur_game_state = vt[i].st;
         DrawX = vt[i].drx;
         DrawY = vt[i].dry;
         cyc(3);
         tick_n(vt[i].ticks);
         @(negedge Clk);
         chk_pos($sformatf("v%0d", i), vt[i].ex, vt[i].ey, vt[i].es);
         chk($sformatf("v%0d_ball", i), 16'(is_ball), 16'(vt[i].eb));
         chk($sformatf("v%0d_xdis", i), 16'(Ball_x_dis), 16'(vt[i].exd));
         chk($sformatf("v%0d_ydis", i), 16'(Ball_y_dis), 16'(vt[i].eyd));
      end

      // fire held: one recoil of 6 ticks, x frozen at 480
      cur_game_state = 4'h3;
      cyc(2);
      @(negedge Clk);
      chk_pos("fire0", 10'd480, 10'd48, 1'b0);
      tick_n(5);
      @(negedge Clk);
      chk_pos("fire5", 10'd480, 10'd48, 1'b0);
      tick_n(1);
      @(negedge Clk);
      chk_pos("fire6", 10'd480, 10'd64, 1'b1);
      tick_n(14);
      @(negedge Clk);
      chk_pos("fire_held", 10'd480, 10'd64, 1'b1);

      // leave fire and return: re-arms
      cur_game_state = 4'h2;
      cyc(2);
      cur_game_state = 4'h3;
      cyc(2);
      tick_n(2);
      @(negedge Clk);
      chk_pos("refire", 10'd480, 10'd48, 1'b0);

      // hidden during recoil aborts on the next edge
      DrawX = 10'd480;
      DrawY = 10'd48;
      @(posedge Clk);
      #1;
      cur_game_state = 4'hF;
      @(posedge Clk);
      #1;
      chk_pos("abort", 10'd320, 10'd64, 1'b1);
      chk("abort_ball_a", 16'(is_ball), 16'd0);
      DrawX = 10'd320;
      DrawY = 10'd64;
      #1;
      chk("abort_ball_b", 16'(is_ball), 16'd0);

      // async reset mid-slide, no clock edge in between
      cur_game_state = 4'h1;
      cyc(3);
      tick_n(17);
      @(negedge Clk);
      chk_pos("slide", 10'd252, 10'd64, 1'b0);
      Reset_n = 1'b0;
      #1;
      chk_pos("async_rst", 10'd320, 10'd64, 1'b1);
      chk("async_rst_ball", 16'(is_ball), 16'd0);
      #1;
      Reset_n = 1'b1;
      cyc(3);
      tick_n(1);
      @(negedge Clk);
      chk_pos("post_rst", 10'd316, 10'd64, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
